riscv_lsu_mem_stage: RTL

//  Load/store execution stage directly downstream of the GPR read ports.

---
 rtl/riscv_lsu_pkg.sv | 52 +++++
 rtl/riscv_lsu_mem_stage_if.sv | 24 ++
 rtl/riscv_lsu_load_align.sv | 36 +++
 rtl/riscv_lsu_mem_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store stage: funct3 codes, FSM states,
// access-size decode, byte-enable and alignment helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Unused encodings (011, 110, 111) fall through to word accesses.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  // 4-bit result: lanes shifted past byte 3 are dropped.
  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
    case (lsu_size(f3))
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (lsu_size(f3))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_mem_stage_if.sv
// Data-memory bus between the load/store stage (master) and memory (slave):
// req/gnt address phase, rvalid/rdata response phase.
interface riscv_lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            gnt;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/riscv_lsu_load_align.sv
// Load result formatting: picks the addressed byte/half lane out of the
// response word and sign- or zero-extends it. Word loads pass through raw.
module riscv_lsu_load_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane select and extension; a half at offset 3 only has its low byte in this word.
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = rdata[15:0];
    sext     = ~funct3[2];
    case (off)
      2'd0: begin byte_sel = rdata[7:0];   half_sel = rdata[15:0];           end
      2'd1: begin byte_sel = rdata[15:8];  half_sel = rdata[23:8];           end
      2'd2: begin byte_sel = rdata[23:16]; half_sel = rdata[31:16];          end
      default: begin byte_sel = rdata[31:24]; half_sel = {8'h00, rdata[31:24]}; end
    endcase
    case (lsu_size(funct3))
      SZ_B:    data = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_mem_stage.sv
// Load/store execution stage: effective address from rs1+imm, req/gnt/rvalid
// data-memory access with timeout, store lane formatting, load writeback.
// Optional build macro RISCV_LSU_MISALIGN_TRAP_EN: misaligned half/word
// accesses are rejected with an lsu_err_o pulse instead of going to the bus.
//
// state | meaning
// IDLE  | ready for issue, no access outstanding
// REQ   | mem req held with stable address/data, waiting for gnt
// WAIT  | granted, waiting for rvalid
module riscv_lsu_mem_stage
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic                 lsu_we_i,
  input  logic [2:0]           lsu_funct3_i,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [4:0]           rd_addr_i,
  riscv_lsu_mem_stage_if.master mem,
  output logic                 wb_valid_o,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 lsu_err_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             req_q, req_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  ea;
  logic [XLEN-1:0]  load_data;
  logic             trap_now;

  assign ea = rs1_data_i + imm_i;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign trap_now = lsu_misaligned(lsu_funct3_i, ea[1:0]);
`else
  assign trap_now = 1'b0;
`endif

  riscv_lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem.rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // Next-state and next-output decode; everything leaving the block is registered.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    req_d      = req_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_valid_i && ready_q) begin
          cnt_d = '0;
          if (trap_now) begin
            err_d = 1'b1;
          end else begin
            state_d = REQ;
            ready_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = {ea[XLEN-1:2], 2'b00};
            we_d    = lsu_we_i;
            be_d    = lsu_be(lsu_funct3_i, ea[1:0]);
            wdata_d = rs2_data_i << {ea[1:0], 3'b000};
            f3_d    = lsu_funct3_i;
            off_d   = ea[1:0];
            rd_d    = rd_addr_i;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (mem.gnt) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.rvalid) begin
          state_d = IDLE;
          ready_d = 1'b1;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      req_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign lsu_ready_o = ready_q;
  assign mem.req     = req_q;
  assign mem.addr    = addr_q;
  assign mem.we      = we_q;
  assign mem.be      = be_q;
  assign mem.wdata   = wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign lsu_err_o   = err_q;

endmodule
